// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - SAP-2 opcode set, instruction lengths and fetch states
package arch_defs_pkg;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_LDI_B = 8'h06,
        OP_STA   = 8'h32,
        OP_LDA   = 8'h3A,
        OP_LDI_A = 8'h3E,
        OP_HLT   = 8'h76,
        OP_ADD_B = 8'h80,
        OP_SUB_B = 8'h90,
        OP_JNZ   = 8'hC2,
        OP_JMP   = 8'hC3,
        OP_JZ    = 8'hCA,
        OP_OUT   = 8'hD3,
        OP_ANI   = 8'hE6,
        OP_JN    = 8'hFA
    } opcode_e;

    typedef enum logic [3:0] {
        S_OP_ADDR,
        S_OP_DATA,
        S_LO_ADDR,
        S_LO_DATA,
        S_HI_ADDR,
        S_HI_DATA,
        S_DECIDE,
        S_ISSUE,
        S_HALT
    } fetch_state_e;

    // Unknown opcodes are one byte long; the control unit decides what they mean.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        case (op)
            OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JNZ, OP_JN: instr_len = 2'd3;
            OP_LDI_A, OP_LDI_B, OP_OUT, OP_ANI:           instr_len = 2'd2;
            default:                                      instr_len = 2'd1;
        endcase
    endfunction

    function automatic logic is_jump(input logic [7:0] op);
        case (op)
            OP_JMP, OP_JZ, OP_JNZ, OP_JN: is_jump = 1'b1;
            default:                      is_jump = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - jump condition evaluation from Z/N flags
module branch_cond
    import arch_defs_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic       flag_zero_i,
    input  logic       flag_negative_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        case (opcode_i)
            OP_JMP:  take_o = 1'b1;
            OP_JZ:   take_o = flag_zero_i;
            OP_JNZ:  take_o = ~flag_zero_i;
            OP_JN:   take_o = flag_negative_i;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - SAP-2 fetch/branch stage: PC, byte fetch, jump resolve, HLT
module instr_fetch_unit
    import arch_defs_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  flag_zero_i,
    input  logic                  flag_negative_i,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand_lo,
    output logic [DATA_WIDTH-1:0] operand_hi,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  branch_taken,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  branch_q, branch_d;
    logic                  take;

    branch_cond u_branch_cond (
        .opcode_i        (opcode_q),
        .flag_zero_i     (flag_zero_i),
        .flag_negative_i (flag_negative_i),
        .take_o          (take)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        branch_d = 1'b0;
        case (state_q)
            S_OP_ADDR: state_d = S_OP_DATA;
            S_OP_DATA: begin
                opcode_d = mem_rdata;
                pc_d     = pc_q + PC_ONE;
                state_d  = (instr_len(mem_rdata) == 2'd1) ? S_DECIDE : S_LO_ADDR;
            end
            S_LO_ADDR: state_d = S_LO_DATA;
            S_LO_DATA: begin
                lo_d    = mem_rdata;
                pc_d    = pc_q + PC_ONE;
                state_d = (instr_len(opcode_q) == 2'd3) ? S_HI_ADDR : S_DECIDE;
            end
            S_HI_ADDR: state_d = S_HI_DATA;
            S_HI_DATA: begin
                hi_d    = mem_rdata;
                pc_d    = pc_q + PC_ONE;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (opcode_q == OP_HLT) begin
                    state_d = S_HALT;
                end else if (is_jump(opcode_q)) begin
                    // Jumps are resolved here and never reach the control unit.
                    if (take) begin
                        pc_d     = {hi_q, lo_q};
                        branch_d = 1'b1;
                    end
                    state_d = S_OP_ADDR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:  if (instr_ready) state_d = S_OP_ADDR;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_OP_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_OP_ADDR;
            pc_q     <= RESET_VECTOR;
            opcode_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            branch_q <= branch_d;
        end
    end

    // The reset state is an address state, so the strobe is masked while reset is held.
    assign mem_rd       = reset & ((state_q == S_OP_ADDR) | (state_q == S_LO_ADDR) |
                                   (state_q == S_HI_ADDR));
    assign mem_addr     = pc_q;
    assign pc_o         = pc_q;
    assign opcode       = opcode_q;
    assign operand_lo   = lo_q;
    assign operand_hi   = hi_q;
    assign branch_taken = branch_q;
    assign instr_valid  = (state_q == S_ISSUE);
    assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with ISA-level model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        flag_zero_i, flag_negative_i;
    logic        instr_valid, instr_ready;
    logic [7:0]  opcode, operand_lo, operand_hi;
    logic [15:0] pc_o;
    logic        branch_taken, halted;

    logic sb_en = 1'b0;
    logic rnd_ready = 1'b0, rnd_z = 1'b0, rnd_n = 1'b0;
    logic dir_ready = 1'b0, dir_z = 1'b0, dir_n = 1'b0;

    assign instr_ready     = sb_en ? rnd_ready : dir_ready;
    assign flag_zero_i     = sb_en ? rnd_z : dir_z;
    assign flag_negative_i = sb_en ? rnd_n : dir_n;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .mem_rdata       (mem_rdata),
        .flag_zero_i     (flag_zero_i),
        .flag_negative_i (flag_negative_i),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .opcode          (opcode),
        .operand_lo      (operand_lo),
        .operand_hi      (operand_hi),
        .pc_o            (pc_o),
        .branch_taken    (branch_taken),
        .halted          (halted)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] br_q[$];
    logic [1:0]  flags_seq [0:63];
    int          hs_count = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int tb_len(input logic [7:0] op);
        case (op)
            8'h3A, 8'h32, 8'hC3, 8'hCA, 8'hC2, 8'hFA: return 3;
            8'h3E, 8'h06, 8'hE6, 8'hD3:               return 2;
            default:                                  return 1;
        endcase
    endfunction

    function automatic bit tb_is_jump(input logic [7:0] op);
        return op == 8'hC3 || op == 8'hCA || op == 8'hC2 || op == 8'hFA;
    endfunction

    function automatic logic [7:0] pick_op(input int i);
        case (i)
            0: return 8'h00;  1: return 8'h3E;  2: return 8'h06;  3: return 8'h3A;
            4: return 8'h32;  5: return 8'h80;  6: return 8'h90;  7: return 8'hE6;
            8: return 8'hD3;  9: return 8'h55;  10: return 8'hFF; 11: return 8'hC3;
            12: return 8'hCA; 13: return 8'hC2; default: return 8'hFA;
        endcase
    endfunction

    // Driver: random back-pressure; flags change only between handshakes.
    always @(posedge clk) begin
        #2;
        if (sb_en) begin
            rnd_ready = ($urandom_range(0, 3) != 0);
            {rnd_z, rnd_n} = flags_seq[hs_count[5:0]];
        end
    end

    // Monitor: compares every handshake and branch pulse against the model queues.
    always @(negedge clk) begin
        if (sb_en) begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) chk("issue_extra", 64'd1, 64'd0);
                else chk("issue", {opcode, operand_lo, operand_hi, pc_o}, exp_q.pop_front());
                hs_count++;
            end
            if (branch_taken) begin
                if (br_q.size() == 0) chk("branch_extra", 64'd1, 64'd0);
                else chk("branch_pc", {mem_rd, mem_addr, pc_o}, {1'b1, br_q[0], br_q[0]});
                if (br_q.size() != 0) void'(br_q.pop_front());
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 8'h76;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int n_hs, output int n_br,
                                  output logic [15:0] br_pc);
        n_hs = 0; n_br = 0; br_pc = 16'h0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) n_hs++;
            if (branch_taken) begin n_br++; br_pc = pc_o; end
            if (halted) break;
        end
        chk("halted", {63'd0, halted}, 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        for (int c = 0; c < budget && !instr_valid; c++) @(negedge clk);
        chk("valid_seen", {63'd0, instr_valid}, 64'd1);
    endtask

    // ISA-level model: walks memory instruction by instruction.
    task automatic run_model(output logic [15:0] halt_pc);
        logic [15:0] pc, a1, a2;
        logic [7:0]  op, lo, hi;
        logic        z, n, take;
        exp_t        e;
        int          k;
        pc = 16'hF000; lo = 8'h00; hi = 8'h00; k = 0;
        exp_q.delete(); br_q.delete();
        for (int s = 0; s < 400; s++) begin
            op = mem[pc];
            a1 = pc + 16'd1;
            a2 = pc + 16'd2;
            if (tb_len(op) >= 2) lo = mem[a1];
            if (tb_len(op) == 3) hi = mem[a2];
            pc = pc + 16'(tb_len(op));
            if (op == 8'h76) break;
            {z, n} = flags_seq[k];
            if (tb_is_jump(op)) begin
                take = (op == 8'hC3) || (op == 8'hCA && z) || (op == 8'hC2 && !z) ||
                       (op == 8'hFA && n);
                if (take) begin
                    pc = {hi, lo};
                    br_q.push_back(pc);
                end
            end else begin
                e.op = op; e.lo = lo; e.hi = hi; e.pc = pc;
                exp_q.push_back(e);
                k++;
            end
        end
        halt_pc = pc;
    endtask

    task automatic gen_prog();
        logic [7:0]  ins_op [0:31];
        logic [15:0] ins_addr [0:31];
        logic [15:0] a, t;
        int          n, j;
        n = $urandom_range(12, 24);
        a = 16'hF000;
        for (int i = 0; i < n; i++) begin
            ins_op[i]   = (i == n - 1) ? 8'h76 : pick_op($urandom_range(0, 14));
            ins_addr[i] = a;
            a = a + 16'(tb_len(ins_op[i]));
        end
        for (int i = 0; i < n; i++) begin
            mem[ins_addr[i]] = ins_op[i];
            if (tb_is_jump(ins_op[i])) begin
                j = $urandom_range(i + 1, n - 1);
                t = ins_addr[j];
                mem[ins_addr[i] + 16'd1] = t[7:0];
                mem[ins_addr[i] + 16'd2] = t[15:8];
            end else begin
                if (tb_len(ins_op[i]) >= 2) mem[ins_addr[i] + 16'd1] = 8'($urandom);
                if (tb_len(ins_op[i]) == 3) mem[ins_addr[i] + 16'd2] = 8'($urandom);
            end
        end
    endtask

    initial begin
        int          n_hs, n_br, n_rd;
        logic [15:0] br_pc, hp, pc_hold;

        // Reset values, then JNZ not taken.
        clear_mem();
        mem[16'hF000] = 8'h3E; mem[16'hF001] = 8'h00;
        mem[16'hF002] = 8'hC2; mem[16'hF003] = 8'h0A; mem[16'hF004] = 8'hF0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc_o, 16'hF000);
        chk("rst_addr", mem_addr, 16'hF000);
        chk("rst_ctl", {mem_rd, instr_valid, branch_taken, halted}, 4'b0000);
        chk("rst_bytes", {opcode, operand_lo, operand_hi}, 24'h0);
        dir_ready = 1'b1; dir_z = 1'b1;
        release_reset();
        #1;
        chk("first_rd", {mem_rd, mem_addr, pc_o}, {1'b1, 16'hF000, 16'hF000});
        run_until_halt(100, n_hs, n_br, br_pc);
        chk("jnz_nt_issue", n_hs, 1);
        chk("jnz_nt_br", n_br, 0);
        chk("jnz_nt_pc", {operand_hi, operand_lo, pc_o}, {8'hF0, 8'h0A, 16'hF006});

        // JNZ taken.
        reset = 1'b0; dir_z = 1'b0;
        release_reset();
        run_until_halt(100, n_hs, n_br, br_pc);
        chk("jnz_t_issue", n_hs, 1);
        chk("jnz_t_pulse", n_br, 1);
        chk("jnz_t_pc", {br_pc, pc_o}, {16'hF00A, 16'hF00B});

        // JMP to HLT, then frozen.
        reset = 1'b0; clear_mem();
        mem[16'hF000] = 8'hC3; mem[16'hF001] = 8'h0C; mem[16'hF002] = 8'hF0;
        release_reset();
        run_until_halt(100, n_hs, n_br, br_pc);
        chk("jmp_br", {n_br[7:0], br_pc}, {8'd1, 16'hF00C});
        chk("hlt_pc", pc_o, 16'hF00D);
        n_rd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_rd || pc_o != 16'hF00D || !halted) n_rd++;
        end
        chk("hlt_frozen", n_rd, 0);

        // Back-pressure on LDI_A 11.
        reset = 1'b0; clear_mem(); dir_ready = 1'b0;
        mem[16'hF000] = 8'h3E; mem[16'hF001] = 8'h11;
        release_reset();
        wait_valid(20);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold", {instr_valid, mem_rd, opcode, operand_lo, pc_o},
                {1'b1, 1'b0, 8'h3E, 8'h11, 16'hF002});
            @(negedge clk);
        end
        dir_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {instr_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'hF002});

        // Three-byte instruction at FFFE wraps its operand fetch.
        reset = 1'b0; clear_mem(); dir_ready = 1'b0;
        mem[16'hF000] = 8'hC3; mem[16'hF001] = 8'hFE; mem[16'hF002] = 8'hFF;
        mem[16'hFFFE] = 8'h3A; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        release_reset();
        wait_valid(40);
        chk("wrap", {opcode, operand_lo, operand_hi, pc_o}, {8'h3A, 8'h34, 8'h12, 16'h0001});
        dir_ready = 1'b1;
        run_until_halt(40, n_hs, n_br, br_pc);
        chk("wrap_hlt", pc_o, 16'h0002);

        // Reset asserted mid S_HI_DATA.
        reset = 1'b0; clear_mem();
        mem[16'hF000] = 8'h3A; mem[16'hF001] = 8'h11; mem[16'hF002] = 8'h22;
        release_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hi_data_pc", {mem_rd, pc_o, operand_lo}, {1'b0, 16'hF002, 8'h11});
        reset = 1'b0;
        #1;
        chk("async_rst", {mem_rd, pc_o, mem_addr, operand_lo}, {1'b0, 16'hF000, 16'hF000, 8'h00});

        // Randomized programs against the model.
        for (int p = 0; p < 6; p++) begin
            reset = 1'b0;
            clear_mem();
            gen_prog();
            for (int i = 0; i < 64; i++) flags_seq[i] = 2'($urandom);
            run_model(hp);
            hs_count = 0;
            sb_en = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 3000 && !halted; c++) @(negedge clk);
            chk("rnd_halted", {63'd0, halted}, 64'd1);
            chk("rnd_halt_pc", pc_o, hp);
            chk("rnd_left", exp_q.size() + br_q.size(), 0);
            sb_en = 1'b0;
            pc_hold = pc_o;
            @(negedge clk);
            chk("rnd_frozen", {mem_rd, pc_o}, {1'b0, pc_hold});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
